// File: rtl/gp_axis_to_apb4_bridge_if.sv
// Bus bundle for the AXI-Stream to APB4 bridge.
// Carries the forward command stream (tdata = write data, tuser = {pprot, pstrb, pwrite, paddr}),
// the backward response stream (tdata = read data, tuser = 2-bit status) and the
// multi-slave APB4 master signals (shared address/data/control, one-hot psel, per-slave
// prdata/pready/pslverr). Modport master is the bridge view, slave is the environment view.
interface gp_axis_to_apb4_bridge_if #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;
  localparam int unsigned USER_W = 3 + STRB_W + 1 + APB_ADDR_WIDTH;

  logic [APB_DATA_WIDTH-1:0]            fwd_tdata_i;
  logic [USER_W-1:0]                    fwd_tuser_i;
  logic                                 fwd_tvalid_i;
  logic                                 fwd_tready_o;
  logic [APB_DATA_WIDTH-1:0]            bwd_tdata_o;
  logic [1:0]                           bwd_tuser_o;
  logic                                 bwd_tvalid_o;
  logic                                 bwd_tready_i;
  logic [APB_ADDR_WIDTH-1:0]            paddr_o;
  logic [APB_DATA_WIDTH-1:0]            pwdata_o;
  logic [STRB_W-1:0]                    pstrb_o;
  logic [2:0]                           pprot_o;
  logic                                 pwrite_o;
  logic [NUM_SLAVES-1:0]                psel_o;
  logic                                 penable_o;
  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] prdata_i;
  logic [NUM_SLAVES-1:0]                pready_i;
  logic [NUM_SLAVES-1:0]                pslverr_i;

  modport master (
    input  fwd_tdata_i, fwd_tuser_i, fwd_tvalid_i, bwd_tready_i,
    input  prdata_i, pready_i, pslverr_i,
    output fwd_tready_o, bwd_tdata_o, bwd_tuser_o, bwd_tvalid_o,
    output paddr_o, pwdata_o, pstrb_o, pprot_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output fwd_tdata_i, fwd_tuser_i, fwd_tvalid_i, bwd_tready_i,
    output prdata_i, pready_i, pslverr_i,
    input  fwd_tready_o, bwd_tdata_o, bwd_tuser_o, bwd_tvalid_o,
    input  paddr_o, pwdata_o, pstrb_o, pprot_o, pwrite_o, psel_o, penable_o
  );
endinterface

// File: rtl/gp_axis_to_apb4_bridge.sv
// AXI-Stream to APB4 master bridge, one transfer outstanding.
// Each accepted forward beat becomes one APB SETUP/ACCESS transfer to the slave picked by
// paddr[SLV_SEL_LSB +: SEL_W]; the result returns as one backward beat with read data and
// status (00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT).
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - master modport: forward/backward streams and APB4 master signals
module gp_axis_to_apb4_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned SLV_SEL_LSB    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  gp_axis_to_apb4_bridge_if.master bus
);
  localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;
  localparam int unsigned AW     = APB_ADDR_WIDTH;
  localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned SEL_W1 = SEL_W + 1;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_DECERR  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state;
  logic [SEL_W-1:0]     sel_q;
  logic [CNT_W-1:0]     cnt;

  // Command fields unpacked from the forward tuser.
  logic [AW-1:0]        in_addr;
  logic                 in_write;
  logic [STRB_W-1:0]    in_strb;
  logic [2:0]           in_prot;
  logic [SEL_W-1:0]     in_idx;
  logic                 in_idx_ok;

  assign in_addr   = bus.fwd_tuser_i[AW-1:0];
  assign in_write  = bus.fwd_tuser_i[AW];
  assign in_strb   = bus.fwd_tuser_i[AW+1 +: STRB_W];
  assign in_prot   = bus.fwd_tuser_i[AW+1+STRB_W +: 3];
  assign in_idx    = in_addr[SLV_SEL_LSB +: SEL_W];
  // Widened compare so a power-of-two NUM_SLAVES never flags a decode error.
  assign in_idx_ok = {1'b0, in_idx} < SEL_W1'(NUM_SLAVES);

  assign bus.fwd_tready_o = (state == IDLE);

  // Response mux from the registered slave index; unselected slaves are ignored.
  logic [APB_DATA_WIDTH-1:0] sel_rdata;
  logic                      sel_ready;
  logic                      sel_slverr;

  always_comb begin
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_rdata  = bus.prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        sel_ready  = bus.pready_i[k];
        sel_slverr = bus.pslverr_i[k];
      end
    end
  end

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      sel_q            <= '0;
      cnt              <= '0;
      bus.paddr_o      <= '0;
      bus.pwdata_o     <= '0;
      bus.pstrb_o      <= '0;
      bus.pprot_o      <= '0;
      bus.pwrite_o     <= 1'b0;
      bus.psel_o       <= '0;
      bus.penable_o    <= 1'b0;
      bus.bwd_tdata_o  <= '0;
      bus.bwd_tuser_o  <= '0;
      bus.bwd_tvalid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fwd_tvalid_i) begin
            bus.paddr_o  <= in_addr;
            bus.pwdata_o <= bus.fwd_tdata_i;
            bus.pstrb_o  <= in_write ? in_strb : '0;
            bus.pprot_o  <= in_prot;
            bus.pwrite_o <= in_write;
            sel_q        <= in_idx;
            cnt          <= '0;
            if (in_idx_ok) begin
              state      <= SETUP;
              bus.psel_o <= NUM_SLAVES'(1) << in_idx;
            end else begin
              state            <= RESP;
              bus.bwd_tvalid_o <= 1'b1;
              bus.bwd_tdata_o  <= '0;
              bus.bwd_tuser_o  <= ST_DECERR;
            end
          end
        end
        SETUP: begin
          state         <= ACCESS;
          bus.penable_o <= 1'b1;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle.
          if (sel_ready) begin
            state            <= RESP;
            bus.psel_o       <= '0;
            bus.penable_o    <= 1'b0;
            bus.bwd_tvalid_o <= 1'b1;
            bus.bwd_tdata_o  <= bus.pwrite_o ? '0 : sel_rdata;
            bus.bwd_tuser_o  <= sel_slverr ? ST_SLVERR : ST_OK;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            state            <= RESP;
            bus.psel_o       <= '0;
            bus.penable_o    <= 1'b0;
            bus.bwd_tvalid_o <= 1'b1;
            bus.bwd_tdata_o  <= '0;
            bus.bwd_tuser_o  <= ST_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.bwd_tready_i) begin
            state            <= IDLE;
            bus.bwd_tvalid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gp_axis_to_apb4_bridge.sv
// Randomized self-checking bench for gp_axis_to_apb4_bridge (3 slaves, timeout 8).
module tb_gp_axis_to_apb4_bridge;
  localparam int unsigned NS  = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LSB = 12;
  localparam int unsigned TO  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gp_axis_to_apb4_bridge_if #(.NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  gp_axis_to_apb4_bridge #(
    .NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .SLV_SEL_LSB(LSB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: outcome of one command from the rules alone.
  // Slave answers pready on ACCESS cycle waits+1; the bridge gives up after TO ACCESS cycles.
  function automatic void model(input logic [31:0] addr, input bit wr, input int waits,
                                input bit err, input logic [31:0] rdata,
                                output bit dec, output int idx, output int acc, output int lat,
                                output logic [31:0] d, output logic [1:0] st);
    idx = int'((addr / 4096) % 4);
    dec = (idx >= int'(NS));
    if (dec) begin
      acc = 0; lat = 1; d = 0; st = 2'd2;
    end else if (waits >= int'(TO)) begin
      acc = TO; lat = TO + 2; d = 0; st = 2'd3;
    end else begin
      acc = waits + 1; lat = acc + 2; d = wr ? 32'd0 : rdata; st = err ? 2'd1 : 2'd0;
    end
  endfunction

  task automatic scramble_slaves();
    bus.pready_i  = NS'($urandom);
    bus.pslverr_i = NS'($urandom);
    bus.prdata_i  = {$urandom, $urandom, $urandom};
  endtask

  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [3:0] strb,
                      input logic [2:0] prot, input logic [31:0] wdata, input int waits,
                      input bit err, input logic [31:0] rdata, input int bp);
    bit dec;
    int idx, acc_exp, lat_exp, cyc, acc;
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
    logic [NS-1:0] exp_sel;
    logic [31:0] hold_d;
    logic [1:0]  hold_s;
    model(addr, wr, waits, err, rdata, dec, idx, acc_exp, lat_exp, exp_d, exp_s);
    exp_sel = '0;
    if (!dec) exp_sel[idx] = 1'b1;

    @(negedge clk);
    chk("fwd_tready_idle", 64'(bus.fwd_tready_o), 64'd1);
    bus.fwd_tdata_i  = wdata;
    bus.fwd_tuser_i  = {prot, strb, wr, addr};
    bus.fwd_tvalid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.fwd_tvalid_i = 1'b0;
    bus.fwd_tdata_i  = $urandom;
    bus.fwd_tuser_i  = {8'($urandom), $urandom};

    cyc = 0;
    acc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      scramble_slaves();
      if (!dec) bus.pready_i[idx] = 1'b0;
      if (bus.bwd_tvalid_o) break;
      if (cyc > 40) begin
        chk("resp_wait_bound", 64'(bus.bwd_tvalid_o), 64'd1);
        return;
      end
      chk("fwd_tready_busy", 64'(bus.fwd_tready_o), 64'd0);
      chk("psel", 64'(bus.psel_o), 64'(exp_sel));
      if (!dec) begin
        chk("penable", 64'(bus.penable_o), 64'(cyc > 1));
        chk("paddr", 64'(bus.paddr_o), 64'(addr));
        chk("pwrite", 64'(bus.pwrite_o), 64'(wr));
        chk("pstrb", 64'(bus.pstrb_o), 64'(wr ? strb : 4'd0));
        chk("pprot", 64'(bus.pprot_o), 64'(prot));
        chk("pwdata", 64'(bus.pwdata_o), 64'(wdata));
        if (bus.penable_o) begin
          acc++;
          bus.pready_i[idx]           = (acc - 1 == waits);
          bus.pslverr_i[idx]          = err;
          bus.prdata_i[idx*DW +: DW]  = rdata;
        end
      end
    end

    chk("latency", 64'(cyc), 64'(lat_exp));
    chk("access_cycles", 64'(acc), 64'(acc_exp));
    chk("resp_data", 64'(bus.bwd_tdata_o), 64'(exp_d));
    chk("resp_status", 64'(bus.bwd_tuser_o), 64'(exp_s));
    chk("psel_resp", 64'(bus.psel_o), 64'd0);
    chk("penable_resp", 64'(bus.penable_o), 64'd0);
    hold_d = bus.bwd_tdata_o;
    hold_s = bus.bwd_tuser_o;

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      scramble_slaves();
      chk("bp_valid", 64'(bus.bwd_tvalid_o), 64'd1);
      chk("bp_data", 64'(bus.bwd_tdata_o), 64'(exp_d));
      chk("bp_status", 64'(bus.bwd_tuser_o), 64'(exp_s));
      chk("bp_fwd_tready", 64'(bus.fwd_tready_o), 64'd0);
      chk("bp_psel", 64'(bus.psel_o), 64'd0);
    end

    bus.bwd_tready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.bwd_tready_i = 1'b0;
    @(negedge clk);
    chk("resp_done_valid", 64'(bus.bwd_tvalid_o), 64'd0);
    chk("resp_done_ready", 64'(bus.fwd_tready_o), 64'd1);
    if (hold_d !== exp_d || hold_s !== exp_s) ; // values already checked above
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    bus.fwd_tdata_i  = 32'hCAFE_0001;
    bus.fwd_tuser_i  = {3'd0, 4'hF, 1'b1, 32'h0000_0010};
    bus.fwd_tvalid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.fwd_tvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      scramble_slaves();
      bus.pready_i[0] = 1'b0;
    end
    chk("rst_pre_psel", 64'(bus.psel_o), 64'd1);
    chk("rst_pre_penable", 64'(bus.penable_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_psel", 64'(bus.psel_o), 64'd0);
    chk("rst_penable", 64'(bus.penable_o), 64'd0);
    chk("rst_fwd_tready", 64'(bus.fwd_tready_o), 64'd1);
    chk("rst_bwd_tvalid", 64'(bus.bwd_tvalid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 64'(bus.bwd_tvalid_o), 64'd0);
      chk("post_rst_psel", 64'(bus.psel_o), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, waits;
    rst              = 1'b1;
    bus.fwd_tdata_i  = '0;
    bus.fwd_tuser_i  = '0;
    bus.fwd_tvalid_i = 1'b0;
    bus.bwd_tready_i = 1'b0;
    bus.prdata_i     = '0;
    bus.pready_i     = '0;
    bus.pslverr_i    = '0;
    repeat (2) @(negedge clk);
    chk("reset_fwd_tready", 64'(bus.fwd_tready_o), 64'd1);
    chk("reset_bwd_tvalid", 64'(bus.bwd_tvalid_o), 64'd0);
    chk("reset_psel", 64'(bus.psel_o), 64'd0);
    chk("reset_penable", 64'(bus.penable_o), 64'd0);
    chk("reset_paddr", 64'(bus.paddr_o), 64'd0);
    chk("reset_bwd_tdata", 64'(bus.bwd_tdata_o), 64'd0);
    chk("reset_bwd_tuser", 64'(bus.bwd_tuser_o), 64'd0);
    rst = 1'b0;

    // Directed corner cases.
    xfer(32'h0000_1004, 1'b0, 4'hF, 3'd2, 32'h1111_2222, 0,   1'b0, 32'hDEAD_BEEF, 0);
    xfer(32'h0000_2000, 1'b1, 4'b0101, 3'd1, 32'hA5A5_5A5A, 3, 1'b0, 32'h7777_7777, 0);
    xfer(32'h0000_3000, 1'b0, 4'hF, 3'd0, 32'h0,         0,   1'b0, 32'h1234_5678, 0);
    xfer(32'h0000_0040, 1'b0, 4'hF, 3'd0, 32'h0,         100, 1'b0, 32'h5555_AAAA, 0);
    xfer(32'h0000_1040, 1'b0, 4'hF, 3'd0, 32'h0,         7,   1'b0, 32'h0BAD_F00D, 0);
    xfer(32'h0000_0008, 1'b0, 4'hF, 3'd4, 32'h0,         1,   1'b1, 32'h1234_5678, 5);
    xfer(32'h0000_2010, 1'b1, 4'hC, 3'd3, 32'hFEED_0001, 0,   1'b1, 32'hFFFF_FFFF, 2);
    reset_mid_access();
    xfer(32'h0000_1004, 1'b0, 4'hF, 3'd0, 32'h0,         2,   1'b0, 32'hC0DE_0042, 1);

    // Randomized commands.
    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      waits = r % 4;
      else if (r == 6) waits = 7;
      else if (r == 7) waits = 8;
      else             waits = 20;
      xfer($urandom, 1'($urandom), 4'($urandom), 3'($urandom), $urandom, waits,
           1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gp_axis_to_apb4_bridge.md
Name: gp_axis_to_apb4_bridge

Overview:
AXI-Stream to APB4 master bridge, multi-slave. Each forward beat carries one APB transfer: address, write flag, strobes and protection in tuser, write data in tdata. The block decodes the address to one of NUM_SLAVES APB4 slaves, runs a SETUP/ACCESS transfer with an optional ACCESS timeout, and returns read data plus a 2-bit status on the backward stream. It sits between a command/packet engine and the peripheral register fabric, with one transfer outstanding at a time.

Parameters:
NUM_SLAVES, 4, number of APB slaves (1..16)
APB_ADDR_WIDTH, 32, APB address width
APB_DATA_WIDTH, 32, APB/AXI-S data width (multiple of 8)
SLV_SEL_LSB, 12, LSB of slave-index field in paddr; field width SEL_W = max(1, clog2(NUM_SLAVES))
TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables timeout
Derived, not overridable: STRB_W = APB_DATA_WIDTH/8; USER_W = 3+STRB_W+1+APB_ADDR_WIDTH

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
fwd_tdata_i  in  APB_DATA_WIDTH  write data
fwd_tuser_i  in  USER_W  {pprot[2:0], pstrb[STRB_W-1:0], pwrite, paddr}
fwd_tvalid_i  in  1  command valid
fwd_tready_o  out  1  command accepted
bwd_tdata_o  out  APB_DATA_WIDTH  read data (0 for writes and errors)
bwd_tuser_o  out  2  status: 00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
bwd_tvalid_o  out  1  response valid
bwd_tready_i  in  1  response accepted
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  APB_DATA_WIDTH  APB write data
pstrb_o  out  STRB_W  APB4 write strobes (forced 0 on reads)
pprot_o  out  3  APB4 protection
pwrite_o  out  1  APB direction
psel_o  out  NUM_SLAVES  one-hot slave select
penable_o  out  1  APB enable
prdata_i  in  NUM_SLAVES*APB_DATA_WIDTH  per-slave read data, slave k at [k*W +: W]
pready_i  in  NUM_SLAVES  per-slave ready
pslverr_i  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, all outputs 0 except fwd_tready_o = 1. Asserting rst_i mid-transfer drops psel/penable/bwd_tvalid immediately. No response is issued for the aborted command.
- fwd_tready_o = (state == IDLE), combinational from state only. On a fwd handshake, tdata/tuser are registered into the command register.
- idx = paddr[SLV_SEL_LSB +: SEL_W]. idx >= NUM_SLAVES gives DECERR: no APB activity, RESP on the next cycle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: handshake -> SETUP (valid idx) or RESP (DECERR).
  - SETUP: psel_o[idx] = 1, penable_o = 0 -> ACCESS.
  - ACCESS: psel_o[idx] = 1, penable_o = 1.
    - pready_i[idx] = 1 -> RESP; capture prdata[idx] (reads only) and status 01 if pslverr_i[idx], else 00.
    - Timeout counter reaches TIMEOUT_CYCLES with no pready -> RESP, status 11, data 0.
  - RESP: bwd_tvalid_o = 1, tdata/tuser held stable. bwd handshake -> IDLE.
- Latency, valid decode, zero wait states: handshake at edge N, SETUP during cycle N+1, ACCESS N+2 (pready sampled), bwd_tvalid high from N+3. Next command accepted the cycle after bwd handshake, giving a minimum of 4 cycles per transfer.
- Timeout counter is cleared on SETUP entry and increments each ACCESS cycle without pready. pready in the same cycle the counter hits the limit wins (status 00/01).
- paddr/pwrite/pwdata/pstrb/pprot are held constant from SETUP through ACCESS exit. pslverr/prdata are ignored on writes except that pslverr still sets status 01.
- Unselected slaves' pready/pslverr/prdata are ignored. psel_o is never multi-hot.

Test Plan:
- Read with no wait states: tuser addr 0x0000_1004 (idx 1), pwrite=0; slave1 prdata=0xDEADBEEF, pready=1 -> psel_o=4'b0010, bwd_tvalid at N+3, tdata 0xDEADBEEF, tuser 00.
- Write with 3 wait states and strobe 4'b0101 to addr 0x0000_3000 -> pstrb_o=0101 and psel_o=1000 held for 4 ACCESS cycles, response tdata 0, status 00.
- Decode error, NUM_SLAVES=3, addr 0x0000_3000 -> psel_o stays 0, bwd_tvalid at N+1, status 10.
- Timeout, TIMEOUT_CYCLES=8, slave never ready -> exactly 8 ACCESS cycles, then psel/penable drop, status 11, data 0. Separate case: pready on the 8th cycle -> status 00.
- Backpressure: bwd_tready=0 for 5 cycles -> response stable, fwd_tready_o=0 and no new APB transfer. pslverr=1 read -> status 01 with prdata captured.
- Assert rst_i during ACCESS -> psel_o/penable_o go 0 before the next edge, fwd_tready_o=1. Next command completes normally.
